lock_hex_display: RTL and testbench

LOCK_HEX_DISPLAY -- requirements
Module: lock_hex_display

---
 rtl/lock_hex_display_if.sv | 26 ++
 rtl/lock_hex_display.sv | 145 ++++++++++++++
 tb/tb_lock_hex_display.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lock_hex_display_if.sv
// Bus between the lock FSM (master) and the six-digit seven-segment display (slave).
interface lock_hex_display_if;
   logic [3:0] digit_in;
   logic       digit_valid;
   logic [1:0] result;
   logic       result_valid;
   logic       clear;
   logic [6:0] HEX0;
   logic [6:0] HEX1;
   logic [6:0] HEX2;
   logic [6:0] HEX3;
   logic [6:0] HEX4;
   logic [6:0] HEX5;
   logic       msg_active;
   logic [2:0] digit_count;

   modport master (
      output digit_in, digit_valid, result, result_valid, clear,
      input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, msg_active, digit_count
   );

   modport slave (
      input  digit_in, digit_valid, result, result_valid, clear,
      output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, msg_active, digit_count
   );
endinterface

// File: rtl/lock_hex_display.sv
// Six-digit entry/message display for the combination lock, active-low segments.
// Optional message blinking is enabled by defining LOCK_BLINK_EN.
module lock_hex_display #(
   parameter int unsigned BLINK_DIV = 4
) (
   input logic               clk,
   input logic               rst_n,
   lock_hex_display_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ENTRY, MSG} state_t;

   localparam logic [6:0]      DASH     = 7'h3F;
   localparam logic [6:0]      BLANK    = 7'h7F;
   localparam logic [5:0][6:0] MSG_OPEN = {7'h7F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B};
   localparam logic [5:0][6:0] MSG_CLSD = {7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21};
   localparam logic [5:0][6:0] MSG_ERR  = {7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h40, 7'h2F};

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [5:0][3:0] digits_q, digits_d;
   logic [2:0]      count_q, count_d;
   logic [1:0]      result_q, result_d;
   logic [5:0][6:0] hex_q, hex_d;
   logic            msg_q;
   logic            phase_d;

   // Priority: clear, then any result strobe (consumes the cycle), then digit.
   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      count_d  = count_q;
      result_d = result_q;
      if (bus.clear) begin
         state_d  = IDLE;
         digits_d = '0;
         count_d  = '0;
      end else if (state_q != MSG) begin
         if (bus.result_valid) begin
            if (bus.result != 2'b00) begin
               state_d  = MSG;
               result_d = bus.result;
            end
         end else if (bus.digit_valid) begin
            state_d  = ENTRY;
            digits_d = {digits_q[4:0], bus.digit_in};
            if (count_q != 3'd6) count_d = count_q + 3'd1;
         end
      end
   end

`ifdef LOCK_BLINK_EN
   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   logic [CW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q;

   // Counter and phase restart whenever MSG is (re)entered.
   always_comb begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
      if (state_q == MSG && state_d == MSG) begin
         if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
            phase_d = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end
`else
   // Steady message: phase is permanently on for any legal divisor.
   assign phase_d = (BLINK_DIV >= 1);
`endif

   logic [5:0][6:0] digit_hex;
   logic [5:0]      filled;

   for (genvar gi = 0; gi < 6; gi++) begin : g_pos
      assign digit_hex[gi] = glyph(digits_d[gi]);
      assign filled[gi]    = (count_d > 3'(gi));
   end

   always_comb begin
      hex_d = {6{DASH}};
      case (state_d)
         ENTRY: begin
            for (int i = 0; i < 6; i++) begin
               if (filled[i]) hex_d[i] = digit_hex[i];
            end
         end
         MSG: begin
            if (!phase_d)                hex_d = {6{BLANK}};
            else if (result_d == 2'b01)  hex_d = MSG_OPEN;
            else if (result_d == 2'b10)  hex_d = MSG_CLSD;
            else                         hex_d = MSG_ERR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         digits_q <= '0;
         count_q  <= '0;
         result_q <= '0;
         hex_q    <= {6{DASH}};
         msg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         count_q  <= count_d;
         result_q <= result_d;
         hex_q    <= hex_d;
         msg_q    <= (state_d == MSG);
      end
   end

   assign bus.HEX0        = hex_q[0];
   assign bus.HEX1        = hex_q[1];
   assign bus.HEX2        = hex_q[2];
   assign bus.HEX3        = hex_q[3];
   assign bus.HEX4        = hex_q[4];
   assign bus.HEX5        = hex_q[5];
   assign bus.msg_active  = msg_q;
   assign bus.digit_count = count_q;
endmodule

// File: tb/tb_lock_hex_display.sv
// Table-driven bench for lock_hex_display with a scoreboard queue of expected outputs.
module tb_lock_hex_display;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lock_hex_display_if bus();

   lock_hex_display #(.BLINK_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   localparam logic [6:0]  D       = 7'h3F;
   localparam logic [41:0] DASH6   = {6{7'h3F}};
   localparam logic [41:0] BLANK6  = {6{7'h7F}};
   localparam logic [41:0] OPEN6   = {7'h7F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B};
   localparam logic [41:0] CLOSED6 = {7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21};
   localparam logic [41:0] ERR6    = {7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h40, 7'h2F};

   typedef struct {
      logic        rst_n;
      logic        clr;
      logic        rv;
      logic [1:0]  res;
      logic        dv;
      logic [3:0]  d;
      logic [41:0] hex;
      logic        msg;
      logic [2:0]  cnt;
   } vec_t;

   typedef struct {
      logic [41:0] hex;
      logic        msg;
      logic [2:0]  cnt;
      int          id;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   tests = 0;
   int   failures = 0;

   task automatic add(input logic r, input logic c, input logic rv, input logic [1:0] res,
                      input logic dv, input logic [3:0] d,
                      input logic [41:0] hex, input logic m, input logic [2:0] n);
      vec_t v;
      v.rst_n = r; v.clr = c; v.rv = rv; v.res = res; v.dv = dv; v.d = d;
      v.hex = hex; v.msg = m; v.cnt = n;
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int id);
      exp_t e;
      exp_t got_e;
      logic [41:0] got;
      @(negedge clk);
      rst_n            = v.rst_n;
      bus.clear        = v.clr;
      bus.result_valid = v.rv;
      bus.result       = v.res;
      bus.digit_valid  = v.dv;
      bus.digit_in     = v.d;
      e.hex = v.hex; e.msg = v.msg; e.cnt = v.cnt; e.id = id;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got_e = sb.pop_front();
      got   = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
      tests++;
      if (got !== got_e.hex || bus.msg_active !== got_e.msg || bus.digit_count !== got_e.cnt) begin
         failures++;
         $display("FAIL step%0d: got hex=%h msg=%b cnt=%0d, expected hex=%h msg=%b cnt=%0d",
                  got_e.id, got, bus.msg_active, bus.digit_count, got_e.hex, got_e.msg, got_e.cnt);
      end else begin
         $display("[TB] step%0d hex=%h msg=%b cnt=%0d ok", got_e.id, got, bus.msg_active, bus.digit_count);
      end
   endtask

   task automatic idle_vec(input logic [41:0] hex, input logic m, input logic [2:0] n, input int id);
      vec_t v;
      v.rst_n = 1'b1; v.clr = 1'b0; v.rv = 1'b0; v.res = 2'b00; v.dv = 1'b0; v.d = 4'h0;
      v.hex = hex; v.msg = m; v.cnt = n;
      apply(v, id);
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0;
      bus.clear = 1'b0; bus.result_valid = 1'b0; bus.result = 2'b00;
      bus.digit_valid = 1'b0; bus.digit_in = 4'h0;

      // reset, entry 8,3,8,4,8,2 then OPEN
      add(0,0,0,2'b00,0,4'h0, DASH6, 0, 0);
      add(1,0,0,2'b00,1,4'h8, {D,D,D,D,D,7'h00}, 0, 1);
      add(1,0,0,2'b00,1,4'h3, {D,D,D,D,7'h00,7'h30}, 0, 2);
      add(1,0,0,2'b00,1,4'h8, {D,D,D,7'h00,7'h30,7'h00}, 0, 3);
      add(1,0,0,2'b00,1,4'h4, {D,D,7'h00,7'h30,7'h00,7'h19}, 0, 4);
      add(1,0,0,2'b00,1,4'h8, {D,7'h00,7'h30,7'h00,7'h19,7'h00}, 0, 5);
      add(1,0,0,2'b00,1,4'h2, {7'h00,7'h30,7'h00,7'h19,7'h00,7'h24}, 0, 6);
      add(1,0,1,2'b01,0,4'h0, OPEN6, 1, 6);
      add(1,0,0,2'b00,0,4'h0, OPEN6, 1, 6);
      add(1,1,0,2'b00,0,4'h0, DASH6, 0, 0);
      // entry 8,3,8,9,8,2 then CLOSED; later digit and result ignored
      add(1,0,0,2'b00,1,4'h8, {D,D,D,D,D,7'h00}, 0, 1);
      add(1,0,0,2'b00,1,4'h3, {D,D,D,D,7'h00,7'h30}, 0, 2);
      add(1,0,0,2'b00,1,4'h8, {D,D,D,7'h00,7'h30,7'h00}, 0, 3);
      add(1,0,0,2'b00,1,4'h9, {D,D,7'h00,7'h30,7'h00,7'h10}, 0, 4);
      add(1,0,0,2'b00,1,4'h8, {D,7'h00,7'h30,7'h00,7'h10,7'h00}, 0, 5);
      add(1,0,0,2'b00,1,4'h2, {7'h00,7'h30,7'h00,7'h10,7'h00,7'h24}, 0, 6);
      add(1,0,1,2'b10,0,4'h0, CLOSED6, 1, 6);
      add(1,0,0,2'b00,1,4'h5, CLOSED6, 1, 6);
      add(1,0,1,2'b01,0,4'h0, CLOSED6, 1, 6);
      add(1,1,0,2'b00,0,4'h0, DASH6, 0, 0);
      // eight digits 1..8, saturation at 6, then ERROR
      add(1,0,0,2'b00,1,4'h1, {D,D,D,D,D,7'h79}, 0, 1);
      add(1,0,0,2'b00,1,4'h2, {D,D,D,D,7'h79,7'h24}, 0, 2);
      add(1,0,0,2'b00,1,4'h3, {D,D,D,7'h79,7'h24,7'h30}, 0, 3);
      add(1,0,0,2'b00,1,4'h4, {D,D,7'h79,7'h24,7'h30,7'h19}, 0, 4);
      add(1,0,0,2'b00,1,4'h5, {D,7'h79,7'h24,7'h30,7'h19,7'h12}, 0, 5);
      add(1,0,0,2'b00,1,4'h6, {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02}, 0, 6);
      add(1,0,0,2'b00,1,4'h7, {7'h24,7'h30,7'h19,7'h12,7'h02,7'h78}, 0, 6);
      add(1,0,0,2'b00,1,4'h8, {7'h30,7'h19,7'h12,7'h02,7'h78,7'h00}, 0, 6);
      add(1,0,1,2'b11,0,4'h0, ERR6, 1, 6);
      add(1,1,0,2'b00,0,4'h0, DASH6, 0, 0);
      // priority corners
      add(1,0,0,2'b00,1,4'hA, {D,D,D,D,D,7'h08}, 0, 1);
      add(1,1,1,2'b01,0,4'h0, DASH6, 0, 0);
      add(1,0,0,2'b00,1,4'hF, {D,D,D,D,D,7'h0E}, 0, 1);
      add(1,0,1,2'b10,1,4'h5, CLOSED6, 1, 1);
      add(1,1,0,2'b00,0,4'h0, DASH6, 0, 0);
      add(1,0,1,2'b00,0,4'h0, DASH6, 0, 0);
      // reset mid-entry and mid-message, reset dominating strobes
      add(1,0,0,2'b00,1,4'hB, {D,D,D,D,D,7'h03}, 0, 1);
      add(1,0,0,2'b00,1,4'hC, {D,D,D,D,7'h03,7'h46}, 0, 2);
      add(1,0,0,2'b00,1,4'hD, {D,D,D,7'h03,7'h46,7'h21}, 0, 3);
      add(0,0,0,2'b00,1,4'hE, DASH6, 0, 0);
      add(1,0,0,2'b00,1,4'h0, {D,D,D,D,D,7'h40}, 0, 1);
      add(1,0,1,2'b11,0,4'h0, ERR6, 1, 1);
      add(0,1,1,2'b01,1,4'h3, DASH6, 0, 0);
      add(1,0,0,2'b00,1,4'hE, {D,D,D,D,D,7'h06}, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i);
      end

      // message display over time: blinking with LOCK_BLINK_EN, steady otherwise
      v.rst_n = 1'b1; v.clr = 1'b1; v.rv = 1'b0; v.res = 2'b00; v.dv = 1'b0; v.d = 4'h0;
      v.hex = DASH6; v.msg = 1'b0; v.cnt = 3'd0;
      apply(v, 100);
      v.clr = 1'b0; v.rv = 1'b1; v.res = 2'b01;
      v.hex = OPEN6; v.msg = 1'b1;
      apply(v, 101);
      for (int k = 1; k < 12; k++) begin
`ifdef LOCK_BLINK_EN
         idle_vec((((k / 4) % 2) == 0) ? OPEN6 : BLANK6, 1'b1, 3'd0, 101 + k);
`else
         idle_vec(OPEN6, 1'b1, 3'd0, 101 + k);
`endif
      end
      v.clr = 1'b1; v.rv = 1'b0; v.res = 2'b00;
      v.hex = DASH6; v.msg = 1'b0;
      apply(v, 120);
      for (int k = 0; k < 3; k++) begin
         idle_vec(DASH6, 1'b0, 3'd0, 121 + k);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
